// File: rtl/decode_sequencer_pkg.sv
// decode_sequencer_pkg: shared Viterbi decode definitions (FSM encoding, size defaults).
package decode_sequencer_pkg;
    localparam int NUM_PAIRS_DEF  = 8;
    localparam int TB_TIMEOUT_DEF = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STEP,
        S_TB_WAIT,
        S_RELEASE,
        S_GUARD
    } state_t;
endpackage

// File: rtl/decode_sequencer.sv
// decode_sequencer: feeds a latched packet pair-by-pair to the ACS stage, then runs traceback.
module decode_sequencer
    import decode_sequencer_pkg::*;
#(
    parameter int NUM_PAIRS  = NUM_PAIRS_DEF,
    parameter int TB_TIMEOUT = TB_TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pkt_valid,
    input  logic [2*NUM_PAIRS-1:0] pkt_data,
    output logic                   renew,
    output logic [1:0]             bp_out,
    output logic                   bp_valid,
    input  logic                   acs_ready,
    output logic [2:0]             step_idx,
    output logic                   acs_clear,
    output logic                   tb_start,
    input  logic                   tb_done,
    output logic                   busy,
    output logic                   tb_err,
    output logic [7:0]             pkt_count
);
    localparam int            CW   = $clog2(TB_TIMEOUT + 1);
    localparam logic [2:0]    LAST = 3'(NUM_PAIRS - 1);
    localparam logic [CW-1:0] TMO  = CW'(TB_TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic [2*NUM_PAIRS-1:0] pkt_q, pkt_d;
    logic [2:0]             step_idx_q, step_idx_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   tb_err_q, tb_err_d;
    logic [7:0]             pkt_count_q, pkt_count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pkt_q       <= '0;
            step_idx_q  <= '0;
            cnt_q       <= '0;
            tb_err_q    <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            pkt_q       <= pkt_d;
            step_idx_q  <= step_idx_d;
            cnt_q       <= cnt_d;
            tb_err_q    <= tb_err_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (pkt_valid) state_d = S_LOAD;
            S_LOAD:    state_d = S_STEP;
            S_STEP:    if (acs_ready && step_idx_q == LAST) state_d = S_TB_WAIT;
            S_TB_WAIT: if (tb_done || cnt_q == TMO) state_d = S_RELEASE;
            S_RELEASE: state_d = S_GUARD;
            default:   state_d = S_IDLE;
        endcase
    end

    // tb_done takes priority over a coinciding timeout, so tb_err only sets when it is absent
    always_comb begin
        pkt_d       = state_q == S_LOAD ? pkt_data : pkt_q;
        step_idx_d  = state_q == S_LOAD ? 3'd0
                    : (bp_valid && acs_ready && step_idx_q != LAST) ? step_idx_q + 3'd1 : step_idx_q;
        cnt_d       = state_q == S_TB_WAIT ? cnt_q + 1'b1 : '0;
        tb_err_d    = tb_err_q | (state_q == S_TB_WAIT && !tb_done && cnt_q == TMO);
        pkt_count_d = pkt_count_q + {7'd0, renew};
    end

    always_comb begin
        bp_valid  = state_q == S_STEP;
        bp_out    = bp_valid ? pkt_q[{step_idx_q, 1'b0} +: 2] : 2'd0;
        acs_clear = state_q == S_LOAD;
        tb_start  = state_q == S_TB_WAIT && cnt_q == '0;
        renew     = state_q == S_RELEASE;
        busy      = state_q != S_IDLE;
    end

    assign step_idx  = step_idx_q;
    assign tb_err    = tb_err_q;
    assign pkt_count = pkt_count_q;
endmodule
